// File: rtl/mips_run_pkg.sv
// Shared run-controller types: FSM state encoding and status codes.
// Latency and backpressure: none (types only).
package mips_run_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RUN     = 2'd1,
    HALTED  = 2'd2,
    TIMEOUT = 2'd3
  } run_state_e;

  localparam logic [1:0] ST_RUN     = 2'b00;
  localparam logic [1:0] ST_HALT    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear has priority over enable.
// Latency: q updates on the edge after en/clr; no backpressure.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/mips_run_ctrl.sv
// Core reset sequencing, run statistics and end-of-program detection (PC self-loop or cycle budget).
// Latency: all outputs registered, decisions land on the edge sampling the deciding input; no backpressure.
module mips_run_ctrl
  import mips_run_pkg::*;
#(
  parameter int RESET_CYCLES = 10,
  parameter int MAX_CYCLES   = 500,
  parameter int HALT_REPEAT  = 4,
  parameter int HALT_DETECT  = 1,
  parameter int PC_W         = 32,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  pc,
  input  logic             pc_valid,
  input  logic             retire,
  output logic             core_rst,
  output logic             done,
  output logic [1:0]       status,
  output logic [CNT_W-1:0] cycles,
  output logic [CNT_W-1:0] retired,
  output logic [PC_W-1:0]  halt_pc
);

  localparam int HW = $clog2(RESET_CYCLES) + 1;
  localparam int RW = $clog2(HALT_REPEAT + 1) + 1;
  localparam logic [HW-1:0]    HOLD_LAST  = HW'(RESET_CYCLES - 1);
  localparam logic [RW-1:0]    REP_TARGET = RW'(HALT_REPEAT);
  localparam logic [CNT_W-1:0] CYC_LAST   = CNT_W'(MAX_CYCLES - 1);

  run_state_e      state;
  logic [HW-1:0]   hold_cnt;
  logic [RW-1:0]   rep_cnt;
  logic [PC_W-1:0] last_pc;
  logic            last_vld;

  logic          in_run;
  logic          same_pc;
  logic [RW-1:0] rep_next;
  logic          halt_hit;
  logic          timeout_hit;

  assign in_run   = (state == RUN);
  assign same_pc  = last_vld && (pc == last_pc);
  assign rep_next = rep_cnt + 1'b1;
  assign halt_hit = (HALT_DETECT != 0) && in_run && pc_valid && same_pc &&
                    (rep_next == REP_TARGET);
  // cycles is about to become MAX_CYCLES on this edge
  assign timeout_hit = in_run && (cycles == CYC_LAST);

  sat_counter #(.WIDTH(CNT_W)) u_cycles (
    .clk   (clk),
    .reset (reset),
    .clr   (state == HOLD),
    .en    (in_run),
    .q     (cycles)
  );

  sat_counter #(.WIDTH(CNT_W)) u_retired (
    .clk   (clk),
    .reset (reset),
    .clr   (state == HOLD),
    .en    (in_run && retire),
    .q     (retired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= HOLD;
      core_rst <= 1'b1;
      done     <= 1'b0;
      status   <= ST_RUN;
      halt_pc  <= '0;
      hold_cnt <= '0;
      rep_cnt  <= '0;
      last_pc  <= '0;
      last_vld <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (hold_cnt == HOLD_LAST) begin
            state    <= RUN;
            core_rst <= 1'b0;
          end
        end
        RUN: begin
          // bubbles leave the self-loop tracker untouched
          if (pc_valid) begin
            if (same_pc) begin
              rep_cnt <= rep_next;
            end else begin
              last_pc  <= pc;
              last_vld <= 1'b1;
              rep_cnt  <= '0;
            end
          end
          if (halt_hit) begin
            state   <= HALTED;
            halt_pc <= pc;
            status  <= ST_HALT;
            done    <= 1'b1;
          end else if (timeout_hit) begin
            state  <= TIMEOUT;
            status <= ST_TIMEOUT;
            done   <= 1'b1;
          end
        end
        HALTED, TIMEOUT: begin
        end
        default: begin
          state <= HOLD;
        end
      endcase
    end
  end

endmodule
